// File: rtl/dram_ctrl_pkg.sv
// Shared types and default timing for the two-client dram arbiter/sequencer.
package dram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACT,
      ACC,
      PRE,
      REF
   } state_e;

   localparam int unsigned TRCD_DEF    = 2;
   localparam int unsigned TRP_DEF     = 2;
   localparam int unsigned TRFC_DEF    = 4;
   localparam int unsigned REF_INT_DEF = 64;

endpackage

// File: rtl/dram_rr_arb2.sv
// Two-way round-robin pick; the caller registers the returned last value.
module dram_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       last_nxt
);

   always_comb begin
      gnt      = '0;
      last_nxt = last;
      if (en) begin
         if (req == 2'b11) begin
            // tie goes to whichever client was not served last
            gnt      = last ? 2'b01 : 2'b10;
            last_nxt = ~last;
         end else if (req[0]) begin
            gnt      = 2'b01;
            last_nxt = 1'b0;
         end else if (req[1]) begin
            gnt      = 2'b10;
            last_nxt = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dram_arb_ctrl.sv
// Round-robin arbiter and activate/access/precharge sequencer with periodic
// refresh for the 8-bit single-port dram.
module dram_arb_ctrl
   import dram_ctrl_pkg::*;
#(
   parameter int unsigned DW      = 8,
   parameter int unsigned AW      = 4,
   parameter int unsigned TRCD    = TRCD_DEF,
   parameter int unsigned TRP     = TRP_DEF,
   parameter int unsigned TRFC    = TRFC_DEF,
   parameter int unsigned REF_INT = REF_INT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          rid,
   output logic          mem_wr,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_ref,
   output logic          busy
);

   localparam int unsigned TW = 8;
   localparam int unsigned RW = (REF_INT > 2) ? $clog2(REF_INT) : 1;

   state_e        state_q;
   logic [TW-1:0] tmr_q;
   logic [RW-1:0] ref_cnt_q;
   logic          ref_pend_q, last_q, own_q, we_q, rd_pend_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wd_q;
   logic          gnt0_q, gnt1_q, mem_wr_q, mem_rd_q, mem_ref_q, busy_q;
   logic          rvalid_q, rid_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q, rdata_q;

   logic [1:0]    arb_gnt;
   logic          last_d;

   dram_rr_arb2 u_arb (
      .req      ({req1, req0}),
      .last     (last_q),
      .en       ((state_q == IDLE) && !ref_pend_q),
      .gnt      (arb_gnt),
      .last_nxt (last_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         ref_cnt_q   <= RW'(REF_INT - 1);
         ref_pend_q  <= 1'b0;
         last_q      <= 1'b1;
         own_q       <= 1'b0;
         we_q        <= 1'b0;
         rd_pend_q   <= 1'b0;
         addr_q      <= '0;
         wd_q        <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_ref_q   <= 1'b0;
         busy_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rid_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         mem_wdata_q <= '0;

         // memory answers one cycle after the strobe; capture at end of PRE1
         rd_pend_q <= mem_rd_q;
         if (rd_pend_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= mem_rdata;
            rid_q    <= own_q;
         end

         case (state_q)
            IDLE: begin
               if (ref_pend_q) begin
                  state_q    <= REF;
                  ref_pend_q <= 1'b0;
                  tmr_q      <= TW'(TRFC - 1);
                  mem_ref_q  <= 1'b1;
                  busy_q     <= 1'b1;
               end else if (|arb_gnt) begin
                  state_q    <= ACT;
                  tmr_q      <= TW'(TRCD - 1);
                  last_q     <= last_d;
                  own_q      <= arb_gnt[1];
                  we_q       <= arb_gnt[1] ? we1    : we0;
                  addr_q     <= arb_gnt[1] ? addr1  : addr0;
                  wd_q       <= arb_gnt[1] ? wdata1 : wdata0;
                  mem_addr_q <= arb_gnt[1] ? addr1  : addr0;
                  gnt0_q     <= arb_gnt[0];
                  gnt1_q     <= arb_gnt[1];
                  busy_q     <= 1'b1;
               end
            end
            ACT: begin
               if (tmr_q == '0) begin
                  state_q     <= ACC;
                  mem_wr_q    <= we_q;
                  mem_rd_q    <= ~we_q;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= we_q ? wd_q : '0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ACC: begin
               state_q    <= PRE;
               tmr_q      <= TW'(TRP - 1);
               mem_addr_q <= '0;
            end
            PRE: begin
               if (tmr_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            REF: begin
               if (tmr_q == '0) begin
                  state_q   <= IDLE;
                  mem_ref_q <= 1'b0;
                  busy_q    <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // placed after the FSM so an expiry on the consuming cycle keeps pend set
         if (ref_cnt_q == '0) begin
            ref_cnt_q  <= RW'(REF_INT - 1);
            ref_pend_q <= 1'b1;
         end else begin
            ref_cnt_q <= ref_cnt_q - 1'b1;
         end
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign mem_wr    = mem_wr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_ref   = mem_ref_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dram_arb_ctrl.sv
// Bench for dram_arb_ctrl: transaction-level schedule model plus a memory emulation.
module tb_dram_arb_ctrl;

   localparam int unsigned DW = 8, AW = 4;
   localparam int unsigned TRCD = 2, TRP = 2, TRFC = 4, REF_INT = 64;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid, rid, mem_wr, mem_rd, mem_ref, busy;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
   logic [AW-1:0] mem_addr;

   dram_arb_ctrl #(.DW(DW), .AW(AW), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .REF_INT(REF_INT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
      .rdata(rdata), .rvalid(rvalid), .rid(rid),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ref(mem_ref), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          g0, g1, wr, rd, rf, bz, rv, rid, av, wv;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rdata;
   } exp_t;

   exp_t          ex [16];
   int            checks = 0, failures = 0;
   int            k, idle_edge;
   logic          pend, last;
   logic [DW-1:0] mdl_mem [16];
   logic [DW-1:0] emu [16];
   logic          prev_rd;
   logic [AW-1:0] prev_addr;
   logic          g_valid;
   int            gw;
   int            mode;
   logic          c_act [2], c_we [2];
   logic [AW-1:0] c_addr [2];
   logic [DW-1:0] c_wd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, k, obs, expv);
      end
   endtask

   task automatic model_reset();
      k = -1; idle_edge = 0; pend = 1'b0; last = 1'b1; prev_rd = 1'b0; prev_addr = '0;
      g_valid = 1'b0; gw = 0;
      for (int i = 0; i < 16; i++) ex[i] = '0;
   endtask

   // One controller decision per edge: refresh first, then the round-robin winner;
   // the whole operation is scheduled into the future expectation slots at once.
   task automatic model_edge();
      logic          w, twe;
      logic [AW-1:0] ta;
      logic [DW-1:0] td;
      g_valid = 1'b0;
      if (k >= idle_edge) begin
         if (pend) begin
            pend = 1'b0;
            for (int j = 0; j < int'(TRFC); j++) begin
               ex[(k+j)%16].rf = 1'b1; ex[(k+j)%16].bz = 1'b1;
            end
            idle_edge = k + TRFC + 1;
         end else if (req0 || req1) begin
            w = (req0 && req1) ? ~last : req1;
            last = w; g_valid = 1'b1; gw = int'(w);
            twe = w ? we1 : we0; ta = w ? addr1 : addr0; td = w ? wdata1 : wdata0;
            if (w) ex[k%16].g1 = 1'b1; else ex[k%16].g0 = 1'b1;
            for (int j = 0; j <= int'(TRCD + TRP); j++) ex[(k+j)%16].bz = 1'b1;
            for (int j = 0; j <= int'(TRCD); j++) begin
               ex[(k+j)%16].av = 1'b1; ex[(k+j)%16].addr = ta;
            end
            if (twe) begin
               ex[(k+TRCD)%16].wr = 1'b1; ex[(k+TRCD)%16].wv = 1'b1; ex[(k+TRCD)%16].wdata = td;
               mdl_mem[ta] = td;
            end else begin
               ex[(k+TRCD)%16].rd = 1'b1;
               ex[(k+TRCD+2)%16].rv = 1'b1; ex[(k+TRCD+2)%16].rid = w;
               ex[(k+TRCD+2)%16].rdata = mdl_mem[ta];
            end
            idle_edge = k + TRCD + TRP + 2;
         end
      end
      if (k % REF_INT == REF_INT - 1) pend = 1'b1;
   endtask

   task automatic check_outputs();
      exp_t x;
      x = ex[k%16];
      chk("gnt0", gnt0, x.g0);
      chk("gnt1", gnt1, x.g1);
      chk("mem_wr", mem_wr, x.wr);
      chk("mem_rd", mem_rd, x.rd);
      chk("mem_ref", mem_ref, x.rf);
      chk("busy", busy, x.bz);
      chk("rvalid", rvalid, x.rv);
      if (x.rv) begin
         chk("rid", rid, x.rid);
         chk("rdata", rdata, x.rdata);
      end
      if (x.av) chk("mem_addr", mem_addr, x.addr);
      if (x.wv) chk("mem_wdata", mem_wdata, x.wdata);
      ex[k%16] = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt0"}, gnt0, 0);      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_mem_wr"}, mem_wr, 0);  chk({tag, "_mem_rd"}, mem_rd, 0);
      chk({tag, "_mem_ref"}, mem_ref, 0); chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rvalid"}, rvalid, 0);  chk({tag, "_rid"}, rid, 0);
      chk({tag, "_rdata"}, rdata, 0);    chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   task automatic newtx(input int i);
      c_act[i] = 1'b1; c_we[i] = 1'($urandom_range(0, 1));
      c_addr[i] = AW'($urandom_range(0, 3)); c_wd[i] = DW'($urandom);
   endtask

   task automatic step();
      req0 = c_act[0]; we0 = c_we[0]; addr0 = c_addr[0]; wdata0 = c_wd[0];
      req1 = c_act[1]; we1 = c_we[1]; addr1 = c_addr[1]; wdata1 = c_wd[1];
      @(posedge clk);
      k++;
      #1;
      model_edge();
      check_outputs();
      if (mem_wr) emu[mem_addr] = mem_wdata;
      mem_rdata = prev_rd ? emu[prev_addr] : DW'($urandom);
      prev_rd = mem_rd; prev_addr = mem_addr;
      if (g_valid) begin
         c_act[gw] = 1'b0;
         if (mode == 1) newtx(gw);
      end
      if (mode == 2) begin
         for (int i = 0; i < 2; i++) begin
            if (!c_act[i] && $urandom_range(0, 3) == 0) newtx(i);
            else if (c_act[i] && $urandom_range(0, 15) == 0) c_act[i] = 1'b0;
         end
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) begin
         mdl_mem[i] = DW'($urandom); emu[i] = mdl_mem[i];
      end
      for (int i = 0; i < 2; i++) begin
         c_act[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wd[i] = '0;
      end
      mode = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b1;

      // client 0 writes FF to address 3
      c_act[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 4'd3; c_wd[0] = 8'hFF;
      n = 0;
      while (c_act[0] && n < 20) begin step(); n++; end
      chk("write_granted", c_act[0], 0);
      repeat (6) step();

      // client 1 reads address 3 back
      c_act[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 4'd3; c_wd[1] = '0;
      n = 0;
      while (c_act[1] && n < 20) begin step(); n++; end
      chk("read_granted", c_act[1], 0);
      repeat (6) step();

      // both clients held continuously: alternating grants
      mode = 1; newtx(0); newtx(1);
      repeat (40) step();
      mode = 0; c_act[0] = 1'b0; c_act[1] = 1'b0;

      // idle bus across refresh intervals
      repeat (80) step();

      // start an access so refresh becomes pending during its first PRE cycle
      n = 0;
      while (((k + 1) % REF_INT != REF_INT - 4) && n < 200) begin step(); n++; end
      mode = 1; newtx(0);
      repeat (24) step();
      mode = 0; c_act[0] = 1'b0;

      // randomized traffic
      mode = 2;
      repeat (700) step();
      mode = 0; c_act[0] = 1'b0; c_act[1] = 1'b0;

      // reset in the middle of ACT
      n = 0;
      while ((k < idle_edge || pend) && n < 40) begin step(); n++; end
      c_act[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 4'd1;
      n = 0;
      while (c_act[0] && n < 20) begin step(); n++; end
      chk("act_granted", c_act[0], 0);
      #2 rst = 1'b0;
      #1 check_all_zero("async_rst");
      repeat (2) @(negedge clk);
      check_all_zero("held_rst");
      @(negedge clk) rst = 1'b1;
      model_reset();
      c_act[0] = 1'b1; c_act[1] = 1'b1;
      c_we[0] = 1'b1; c_we[1] = 1'b1; c_addr[0] = 4'd5; c_addr[1] = 4'd6;
      c_wd[0] = 8'hA5; c_wd[1] = 8'h5A;
      repeat (20) step();
      chk("tie_after_rst_done", c_act[0] | c_act[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
